cache_mshr_fill_engine: RTL and testbench

Consumer end of the MSHR buffer. Takes the oldest MSHR entry when idle, fetches the missing block from memory, merges the buffered store words into it, and writes the completed block into the cache bank. Its `bank_empty` output is the handshake that lets the MSHR buffer shift its head entry out. One engine per bank, between the MSHR buffer and the memory / bank write ports.

---
 rtl/cache_mshr_fill_engine.sv | 105 ++++++++++
 tb/tb_cache_mshr_fill_engine.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mshr_fill_engine.sv
// MSHR fill engine: takes the head MSHR entry, fetches its block from memory,
// merges the pending store words and hands the finished block to the cache bank.
module cache_mshr_fill_engine #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned UUID_W = 8
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    mshr_valid,
    input  logic [ADDR_W-1:0]       mshr_block_addr,
    input  logic [WORDS-1:0]        mshr_write_status,
    input  logic [WORDS*WORD_W-1:0] mshr_write_block,
    input  logic [UUID_W-1:0]       mshr_uuid,
    output logic                    bank_empty,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_resp_valid,
    input  logic [WORD_W-1:0]       mem_resp_data,
    output logic                    fill_valid,
    input  logic                    fill_ready,
    output logic [ADDR_W-1:0]       fill_addr,
    output logic [WORDS*WORD_W-1:0] fill_data,
    output logic                    fill_dirty,
    output logic [UUID_W-1:0]       fill_uuid
);

    localparam int unsigned BEAT_W = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StFill} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [WORDS-1:0]        status_q;
    logic [WORDS*WORD_W-1:0] wblock_q;
    logic [WORDS*WORD_W-1:0] resp_q;
    logic [UUID_W-1:0]       uuid_q;
    logic [BEAT_W-1:0]       beat_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (mshr_valid) begin
                    // A block fully covered by stores needs no memory read.
                    state_d = (&mshr_write_status) ? StFill : StReq;
                end
            end
            StReq: begin
                if (mem_req_ready) state_d = StResp;
            end
            StResp: begin
                if (mem_resp_valid && (beat_q == BEAT_W'(WORDS - 1))) state_d = StFill;
            end
            StFill: begin
                if (fill_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            status_q <= '0;
            wblock_q <= '0;
            resp_q   <= '0;
            uuid_q   <= '0;
            beat_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && mshr_valid) begin
                addr_q   <= mshr_block_addr;
                status_q <= mshr_write_status;
                wblock_q <= mshr_write_block;
                uuid_q   <= mshr_uuid;
            end
            if (state_q == StReq && mem_req_ready) begin
                beat_q <= '0;
            end
            if (state_q == StResp && mem_resp_valid) begin
                resp_q[beat_q*WORD_W +: WORD_W] <= mem_resp_data;
                beat_q                          <= beat_q + BEAT_W'(1);
            end
        end
    end

    assign bank_empty    = (state_q == StIdle);
    assign mem_req_valid = (state_q == StReq);
    assign fill_valid    = (state_q == StFill);
    assign mem_req_addr  = addr_q;
    assign fill_addr     = addr_q;
    assign fill_dirty    = |status_q;
    assign fill_uuid     = uuid_q;

    // Store words take priority over the fetched words.
    for (genvar i = 0; i < WORDS; i++) begin : g_merge
        assign fill_data[i*WORD_W +: WORD_W] = status_q[i] ? wblock_q[i*WORD_W +: WORD_W]
                                                           : resp_q[i*WORD_W +: WORD_W];
    end

endmodule

// File: tb/tb_cache_mshr_fill_engine.sv
// Self-checking bench for cache_mshr_fill_engine: a scoreboard of expected fills
// is compared against every fill handshake the bench observes.
module tb_cache_mshr_fill_engine;

    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic         mshr_valid = 1'b0;
    logic [31:0]  mshr_block_addr = '0;
    logic [3:0]   mshr_write_status = '0;
    logic [127:0] mshr_write_block = '0;
    logic [7:0]   mshr_uuid = '0;
    logic         bank_empty;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_resp_valid = 1'b0;
    logic [31:0]  mem_resp_data = '0;
    logic         fill_valid;
    logic         fill_ready = 1'b0;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;
    logic         fill_dirty;
    logic [7:0]   fill_uuid;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         dirty;
        logic [7:0]   uuid;
    } fill_t;

    fill_t sb[$];
    fill_t obs[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_req_cycles = 0;

    cache_mshr_fill_engine dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .mshr_valid        (mshr_valid),
        .mshr_block_addr   (mshr_block_addr),
        .mshr_write_status (mshr_write_status),
        .mshr_write_block  (mshr_write_block),
        .mshr_uuid         (mshr_uuid),
        .bank_empty        (bank_empty),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .fill_valid        (fill_valid),
        .fill_ready        (fill_ready),
        .fill_addr         (fill_addr),
        .fill_data         (fill_data),
        .fill_dirty        (fill_dirty),
        .fill_uuid         (fill_uuid)
    );

    always #5 CLK = ~CLK;

    // Record every fill handshake and every cycle a memory request is offered.
    always @(negedge CLK) begin
        if (nRST && fill_valid && fill_ready)
            obs.push_back({fill_addr, fill_data, fill_dirty, fill_uuid});
        if (nRST && mem_req_valid) n_req_cycles++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] merge(input logic [3:0] st, input logic [127:0] blk,
                                           input logic [127:0] rsp);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = st[i] ? blk[i*32 +: 32] : rsp[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [127:0] beat_vec(input logic [31:0] base);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic offer(input logic [31:0] a, input logic [3:0] st, input logic [127:0] blk,
                         input logic [7:0] u);
        int n = 0;
        while (!bank_empty && n < 20) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bank_empty !== 1'b1) begin
            n_err++;
            $display("FAIL offer_idle bank_empty got=%b want=1", bank_empty);
        end
        mshr_valid        = 1'b1;
        mshr_block_addr   = a;
        mshr_write_status = st;
        mshr_write_block  = blk;
        mshr_uuid         = u;
        tick();
        // Keep the buffer merging into its own copy; the engine must ignore it now.
        mshr_valid        = 1'b0;
        mshr_block_addr   = 32'hFFFF_FFF0;
        mshr_write_status = 4'b1111;
        mshr_write_block  = {4{32'hEEEE_EEEE}};
        mshr_uuid         = 8'hEE;
    endtask

    task automatic send_beats(input logic [31:0] base, input int gap);
        for (int i = 0; i < 4; i++) begin
            repeat (gap) begin
                mem_resp_valid = 1'b0;
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + 32'(i);
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        #2;
        n_cmp++;
        if ({bank_empty, mem_req_valid, fill_valid} !== 3'b100 || mem_req_addr !== 32'h0 ||
            fill_data !== 128'h0 || fill_uuid !== 8'h0 || fill_dirty !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values got=%b/%h/%h/%h want=100/0/0/0",
                     {bank_empty, mem_req_valid, fill_valid}, mem_req_addr, fill_data, fill_uuid);
        end
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_cmp++;
            if ({bank_empty, mem_req_valid, fill_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL idle_hold cyc=%0d got=%b want=100", i,
                         {bank_empty, mem_req_valid, fill_valid});
            end
        end
        tick();
    endtask

    task automatic test_clean_miss();
        fill_t exp, got;
        exp = '{addr: 32'h1230, data: beat_vec(32'hA0), dirty: 1'b0, uuid: 8'h05};
        sb.push_back(exp);
        mem_req_ready = 1'b1;
        fill_ready    = 1'b1;
        offer(32'h0000_1230, 4'b0000, 128'h0, 8'h05);
        @(negedge CLK);
        n_cmp++;
        if ({mem_req_valid, bank_empty} !== 2'b10 || mem_req_addr !== 32'h1230) begin
            n_err++;
            $display("FAIL clean_req got=%b/%h want=10/00001230", {mem_req_valid, bank_empty},
                     mem_req_addr);
        end
        tick();
        @(negedge CLK);
        n_cmp++;
        if ({mem_req_valid, bank_empty} !== 2'b00) begin
            n_err++;
            $display("FAIL clean_req_once got=%b want=00", {mem_req_valid, bank_empty});
        end
        send_beats(32'hA0, 0);
        @(negedge CLK);
        n_cmp++;
        if ({fill_valid, bank_empty} !== 2'b10) begin
            n_err++;
            $display("FAIL clean_fill_valid got=%b want=10", {fill_valid, bank_empty});
        end
        tick();
        @(negedge CLK);
        n_cmp++;
        if (bank_empty !== 1'b1) begin
            n_err++;
            $display("FAIL clean_idle_after got=%b want=1", bank_empty);
        end
        n_cmp++;
        if (obs.size() != 1 || sb.size() != 1) begin
            n_err++;
            $display("FAIL clean_fill_count got=%0d want=1", obs.size());
            obs.delete();
            sb.delete();
        end else begin
            got = obs.pop_front();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL clean_fill got=%h want=%h", got, exp);
            end
        end
    endtask

    task automatic test_partial_merge();
        fill_t        exp, got;
        logic [127:0] blk;
        blk = {32'hDEAD_0003, 32'h33, 32'hDEAD_0001, 32'h11};
        exp = '{addr: 32'h4560, data: merge(4'b0101, blk, beat_vec(32'hB0)), dirty: 1'b1,
                uuid: 8'h22};
        sb.push_back(exp);
        offer(32'h0000_4560, 4'b0101, blk, 8'h22);
        tick();
        send_beats(32'hB0, 0);
        @(negedge CLK);
        n_cmp++;
        if (fill_valid !== 1'b1) begin
            n_err++;
            $display("FAIL partial_fill_valid got=%b want=1", fill_valid);
        end
        tick();
        n_cmp++;
        if (obs.size() != 1 || sb.size() != 1) begin
            n_err++;
            $display("FAIL partial_fill_count got=%0d want=1", obs.size());
            obs.delete();
            sb.delete();
        end else begin
            got = obs.pop_front();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL partial_fill got=%h want=%h", got, exp);
            end
        end
    endtask

    task automatic test_full_bypass();
        fill_t        exp, got;
        logic [127:0] blk;
        int           req_before;
        blk = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        exp = '{addr: 32'h9000, data: blk, dirty: 1'b1, uuid: 8'h9A};
        sb.push_back(exp);
        req_before = n_req_cycles;
        offer(32'h0000_9000, 4'b1111, blk, 8'h9A);
        @(negedge CLK);
        n_cmp++;
        if ({fill_valid, mem_req_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL bypass_latency got=%b want=10", {fill_valid, mem_req_valid});
        end
        tick();
        @(negedge CLK);
        n_cmp++;
        if (n_req_cycles != req_before || bank_empty !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_no_req got=%0d/%b want=0/1", n_req_cycles - req_before,
                     bank_empty);
        end
        n_cmp++;
        if (obs.size() != 1 || sb.size() != 1) begin
            n_err++;
            $display("FAIL bypass_fill_count got=%0d want=1", obs.size());
            obs.delete();
            sb.delete();
        end else begin
            got = obs.pop_front();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bypass_fill got=%h want=%h", got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        fill_t        exp, got;
        logic [127:0] blk;
        blk = {32'h0, 32'h0, 32'h55, 32'h0};
        exp = '{addr: 32'h7890, data: merge(4'b0010, blk, beat_vec(32'hE0)), dirty: 1'b1,
                uuid: 8'h3C};
        sb.push_back(exp);
        mem_req_ready = 1'b0;
        fill_ready    = 1'b0;
        offer(32'h0000_7890, 4'b0010, blk, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hBAD0 + 32'(i);
            @(negedge CLK);
            n_cmp++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h7890) begin
                n_err++;
                $display("FAIL bp_req_hold cyc=%0d got=%b/%h want=1/00007890", i, mem_req_valid,
                         mem_req_addr);
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        send_beats(32'hE0, 1);
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hF00 + 32'(i);
            @(negedge CLK);
            n_cmp++;
            if (fill_valid !== 1'b1 || fill_data !== exp.data || fill_addr !== exp.addr ||
                fill_uuid !== exp.uuid || fill_dirty !== exp.dirty) begin
                n_err++;
                $display("FAIL bp_fill_hold cyc=%0d got=%b/%h want=1/%h", i, fill_valid,
                         fill_data, exp.data);
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        fill_ready     = 1'b1;
        tick();
        @(negedge CLK);
        n_cmp++;
        if (bank_empty !== 1'b1) begin
            n_err++;
            $display("FAIL bp_idle_after got=%b want=1", bank_empty);
        end
        n_cmp++;
        if (obs.size() != 1 || sb.size() != 1) begin
            n_err++;
            $display("FAIL bp_fill_count got=%0d want=1", obs.size());
            obs.delete();
            sb.delete();
        end else begin
            got = obs.pop_front();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL bp_fill got=%h want=%h", got, exp);
            end
        end
        mem_req_ready = 1'b1;
    endtask

    task automatic test_reset_mid_resp();
        fill_t exp, got;
        mem_req_ready = 1'b1;
        fill_ready    = 1'b1;
        offer(32'h0000_ABC0, 4'b0000, 128'h0, 8'h77);
        tick();
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hC0 + 32'(i);
            tick();
        end
        mem_resp_valid = 1'b0;
        nRST = 1'b0;
        #1;
        n_cmp++;
        if ({bank_empty, mem_req_valid, fill_valid} !== 3'b100 || mem_req_addr !== 32'h0 ||
            fill_addr !== 32'h0 || fill_data !== 128'h0 || fill_uuid !== 8'h0 ||
            fill_dirty !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_values got=%b/%h/%h/%h want=100/0/0/0",
                     {bank_empty, mem_req_valid, fill_valid}, fill_addr, fill_data, fill_uuid);
        end
        tick();
        nRST = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (obs.size() != 0) begin
            n_err++;
            $display("FAIL rst_no_fill got=%0d want=0", obs.size());
            obs.delete();
        end
        exp = '{addr: 32'hDEF0, data: merge(4'b0100, {32'h0, 32'h7777, 64'h0}, beat_vec(32'hD0)),
                dirty: 1'b1, uuid: 8'h78};
        sb.push_back(exp);
        offer(32'h0000_DEF0, 4'b0100, {32'h0, 32'h7777, 64'h0}, 8'h78);
        tick();
        send_beats(32'hD0, 0);
        tick();
        n_cmp++;
        if (obs.size() != 1 || sb.size() != 1) begin
            n_err++;
            $display("FAIL rst_fill_count got=%0d want=1", obs.size());
            obs.delete();
            sb.delete();
        end else begin
            got = obs.pop_front();
            exp = sb.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL rst_fill got=%h want=%h", got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_partial_merge();
        test_full_bypass();
        test_backpressure();
        test_reset_mid_resp();
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0 || obs.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", sb.size(), obs.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
